// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants for the pushbutton/switch debouncer.
// Holds the default stability length, the counter-width helper and the
// channel indices used when mapping ui_in onto debouncer channels.
package debounce_pkg;

  // Default number of consecutive qualifying samples before a flip.
  localparam int STABLE_CYCLES_DEF = 4;

  // Channel positions within the ui_in-driven input vector.
  localparam int CH_A = 0;
  localparam int CH_B = 1;

  // Width needed to hold counts 0..stable (counter never exceeds stable-1).
  function automatic int cnt_width(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one-bit debouncer.
// Two-flop synchroniser, stability counter and debounced level register.
// Optional macro DEBOUNCE_EDGE_EN builds registered rise/fall pulses;
// without it the rise/fall outputs are tied to 0.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             dout_q;
  logic             dout_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next-state: agreement clears the count; disagreement counts qualifying
  // samples and flips the level on the last one.
  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (s2_q == dout_q) begin
      cnt_d = '0;
    end else if (sample_en) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = s2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Edge pulses appear in the same cycle the level register takes its new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= dout_d & ~dout_q;
      fall_q <= ~dout_d & dout_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: N_CH independent debounce channels sharing one
// sample_en prescaler tick. Edge pulses depend on macro DEBOUNCE_EDGE_EN
// (undefined: rise/fall outputs are constant 0).
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_en,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  // One channel per input bit; all share the same sample qualifier.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .sample_en(sample_en),
      .din      (din[gi]),
      .dout     (dout[gi]),
      .rise     (rise[gi]),
      .fall     (fall[gi])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer (N_CH=2, STABLE_CYCLES=4). Expected edge pulses
// follow DEBOUNCE_EDGE_EN: when undefined, rise/fall must stay 0.
module tb_input_debouncer;

  localparam int SC = 4;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [1:0] din;
  logic [1:0] dout;
  logic [1:0] rise;
  logic [1:0] fall;

  always #5 clk = ~clk;

  input_debouncer #(.N_CH(2), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .din(din),
    .dout(dout), .rise(rise), .fall(fall)
  );

  typedef struct packed {
    logic [1:0] d;
    logic [1:0] r;
    logic [1:0] f;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference state of the behaviour described for each channel.
  logic [1:0] m_s1 = 2'b00;
  logic [1:0] m_s2 = 2'b00;
  logic [1:0] m_dout = 2'b00;
  int         m_cnt[2] = '{0, 0};

  // Drive one clock of stimulus, push the predicted post-edge outputs, then
  // pop and compare after the edge.
  task automatic step(input logic r, input logic en, input logic [1:0] d);
    exp_t       e;
    logic [1:0] mr;
    logic [1:0] mf;
    rst = r; sample_en = en; din = d;
    mr = 2'b00; mf = 2'b00;
    if (r) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_dout = 2'b00; m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (m_s2[c] == m_dout[c]) m_cnt[c] = 0;
        else if (en && m_cnt[c] == SC - 1) begin
          m_dout[c] = m_s2[c];
          m_cnt[c]  = 0;
          if (m_s2[c]) mr[c] = 1'b1; else mf[c] = 1'b1;
        end else if (en) m_cnt[c] = m_cnt[c] + 1;
      end
      m_s2 = m_s1;
      m_s1 = d;
    end
    e.d = m_dout;
    e.r = EDGE_ON ? mr : 2'b00;
    e.f = EDGE_ON ? mf : 2'b00;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty cycle=%0d", cyc);
    end else begin
      e = sb.pop_front();
      $display("cycle=%0d rst=%b en=%b din=%b dout=%b rise=%b fall=%b", cyc, r, en, d, dout, rise, fall);
      if (dout !== e.d || rise !== e.r || fall !== e.f) begin
        bad++;
        $display("FAIL sb_outputs cycle=%0d got d=%b r=%b f=%b want d=%b r=%b f=%b",
                 cyc, dout, rise, fall, e.d, e.r, e.f);
      end
    end
    total++;
    if ((rise & fall) !== 2'b00) begin
      bad++;
      $display("FAIL rise_and_fall cycle=%0d got rise=%b fall=%b want disjoint", cyc, rise, fall);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 2'b11);
    step(1'b1, 1'b1, 2'b11);
    total++;
    if (dout !== 2'b00 || rise !== 2'b00 || fall !== 2'b00) begin
      bad++;
      $display("FAIL reset_state got d=%b r=%b f=%b want 00 00 00", dout, rise, fall);
    end
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, 2'b11);
      if (k == 5) begin
        total++;
        if (dout !== 2'b00) begin bad++; $display("FAIL reset_edge5 got dout=%b want 00", dout); end
      end
      if (k == 6) begin
        total++;
        if (dout !== 2'b11 || rise !== (EDGE_ON ? 2'b11 : 2'b00)) begin
          bad++;
          $display("FAIL reset_edge6 got dout=%b rise=%b want 11 %b", dout, rise, EDGE_ON ? 2'b11 : 2'b00);
        end
      end
      if (k == 7) begin
        total++;
        if (dout !== 2'b11 || rise !== 2'b00) begin
          bad++;
          $display("FAIL reset_edge7 got dout=%b rise=%b want 11 00", dout, rise);
        end
      end
    end
  endtask

  task automatic test_release();
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, 2'b01);
      if (k == 5) begin
        total++;
        if (dout !== 2'b11) begin bad++; $display("FAIL release_edge5 got dout=%b want 11", dout); end
      end
      if (k == 6) begin
        total++;
        if (dout !== 2'b01 || fall[1] !== EDGE_ON) begin
          bad++;
          $display("FAIL release_edge6 got dout=%b fall1=%b want 01 %b", dout, fall[1], EDGE_ON);
        end
      end
      if (k == 7) begin
        total++;
        if (dout !== 2'b01 || fall[1] !== 1'b0) begin
          bad++;
          $display("FAIL release_edge7 got dout=%b fall1=%b want 01 0", dout, fall[1]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic seen;
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 2'b00);
    total++;
    if (dout !== 2'b00) begin bad++; $display("FAIL glitch_pre got dout=%b want 00", dout); end
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin step(1'b0, 1'b1, 2'b01); seen |= dout[0] | rise[0]; end
    for (int k = 0; k < 10; k++) begin step(1'b0, 1'b1, 2'b00); seen |= dout[0] | rise[0]; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL glitch_3clk got seen=%b want 0", seen); end
    // Four high clocks is exactly long enough to flip.
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin step(1'b0, 1'b1, 2'b01); seen |= dout[0]; end
    for (int k = 0; k < 12; k++) begin step(1'b0, 1'b1, 2'b00); seen |= dout[0]; end
    total++;
    if (seen !== 1'b1 || dout !== 2'b00) begin
      bad++;
      $display("FAIL glitch_4clk got seen=%b dout=%b want 1 00", seen, dout);
    end
  endtask

  task automatic test_prescaler();
    int ticks;
    int ticks_at;
    int flip_i;
    ticks = 0; ticks_at = -1; flip_i = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, (i % 4) == 3, 2'b01);
      if ((i % 4) == 3 && i >= 2) ticks++;
      if (dout[0] && flip_i < 0) begin flip_i = i; ticks_at = ticks; end
    end
    total++;
    if (flip_i != 15 || ticks_at != 4) begin
      bad++;
      $display("FAIL prescale_rise got step=%0d ticks=%0d want 15 4", flip_i, ticks_at);
    end
    // Drop ch0, bounce it high for one clock between ticks 2 and 3.
    for (int j = 0; j < 28; j++) begin
      step(1'b0, (j % 4) == 3, (j == 8) ? 2'b01 : 2'b00);
      if (j == 15 || j == 22) begin
        total++;
        if (dout[0] !== 1'b1) begin bad++; $display("FAIL prescale_bounce_hold step=%0d got %b want 1", j, dout[0]); end
      end
      if (j == 23) begin
        total++;
        if (dout[0] !== 1'b0 || fall[0] !== EDGE_ON) begin
          bad++;
          $display("FAIL prescale_bounce_fall got dout0=%b fall0=%b want 0 %b", dout[0], fall[0], EDGE_ON);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 2'b01);
    total++;
    if (dout[0] !== 1'b0) begin bad++; $display("FAIL midcount_pre got %b want 0", dout[0]); end
    step(1'b1, 1'b1, 2'b01);
    total++;
    if (dout !== 2'b00 || rise !== 2'b00) begin
      bad++;
      $display("FAIL midcount_reset got dout=%b rise=%b want 00 00", dout, rise);
    end
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, 2'b01);
      if (k == 5) begin
        total++;
        if (dout[0] !== 1'b0) begin bad++; $display("FAIL midcount_edge5 got %b want 0", dout[0]); end
      end
      if (k == 6) begin
        total++;
        if (dout[0] !== 1'b1 || rise[0] !== EDGE_ON) begin
          bad++;
          $display("FAIL midcount_edge6 got dout0=%b rise0=%b want 1 %b", dout[0], rise[0], EDGE_ON);
        end
      end
      if (k == 7) begin
        total++;
        if (rise[0] !== 1'b0) begin bad++; $display("FAIL midcount_edge7 got rise0=%b want 0", rise[0]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b1; din = 2'b00;
    test_reset();
    test_release();
    test_glitch();
    test_prescaler();
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 2'b00);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Upstream conditioning stage for the board-level pushbutton/switch inputs on ui_in that drive the gate logic.
- Per channel:
  - two-flop synchroniser, then a stability counter;
  - produces a clean level plus single-cycle rise/fall pulses.
- The top-level wrapper derives rst from its active-low pin and feeds debounced levels to the downstream combinational cell.

Parameters:
- N_CH, 2, number of independent input channels.
- STABLE_CYCLES, 4, consecutive qualifying samples of disagreement required before the output flips (>=1).
- CNT_W, $clog2(STABLE_CYCLES+1), counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- sample_en  input  1  counter-advance qualifier (prescaler tick); tie 1 for per-clock sampling.
- din  input  N_CH  raw asynchronous inputs.
- dout  output  N_CH  debounced level.
- rise  output  N_CH  one-cycle pulse on dout 0->1.
- fall  output  N_CH  one-cycle pulse on dout 1->0.

Behaviour:
- Reset (rst=1 at a clk edge) clears everything for all channels: sync flops, counters, dout, rise and fall all go to 0.
- Reset mid-count discards the partial count. The first post-reset edge restarts synchronisation.
- Synchroniser: s1<=din; s2<=s1. Only s2 is used downstream.
- Counter per channel:
  - if s2==dout: cnt<=0, regardless of sample_en;
  - else if sample_en and cnt==STABLE_CYCLES-1: dout<=s2, cnt<=0;
  - else if sample_en: cnt<=cnt+1;
  - else: cnt holds.
- Glitch rejection: any return of s2 to dout before the flip clears the count. Pulses on s2 shorter than STABLE_CYCLES qualifying samples never reach dout.
- Latency, with sample_en=1 and din held: dout changes on the (2+STABLE_CYCLES)th rising edge after din changes. The capture edge counts as the first.
- STABLE_CYCLES=1: dout follows s2 one edge later (latency 3).
- rise/fall:
  - registered, asserted in the same cycle dout first shows the new value;
  - deasserted the next cycle;
  - never both high on one channel.
- Channels are fully independent; simultaneous flips on several channels are legal.
- The counter never exceeds STABLE_CYCLES-1, so there is no wrap.

Optional Feature:
- Macro: DEBOUNCE_EDGE_EN.
- Defined: rise and fall behave as above.
- Undefined: the rise/fall registers are not built. The ports remain and are driven constant 0, and dout behaviour is unchanged.

Decomposition:
- Shared package debounce_pkg:
  - default STABLE_CYCLES constant;
  - CNT_W width function;
  - channel-index constants for the ui_in mapping (CH_A=0, CH_B=1).
- One sub-module, debounce_channel: synchroniser, counter, dout and edge registers for a single bit.
- input_debouncer instantiates N_CH copies in a generate loop and ties sample_en to all of them.

Test Plan:
- Reset: hold rst=1 for 2 edges with din=2'b11 -> dout=0, rise=0, fall=0. After release with din held: dout=2'b11 on the 6th edge, rise=2'b11 for exactly one cycle.
- Glitch reject (STABLE_CYCLES=4, sample_en=1): din[0] high for 3 clocks then low -> dout[0] stays 0, rise[0] never asserts.
- Release: with dout[1]=1, drop din[1] and hold -> dout[1]=0 and fall[1]=1 on the 6th edge, fall[1]=0 on the next.
- Prescaler: sample_en high every 4th clock, din[0] rises and holds -> dout[0] rises only after 4 qualifying sample_en edges following s2 change. Also check that a bounce between ticks resets the count.
- Reset mid-count: din[0]=1, assert rst after 3 counted samples -> cnt, dout and rise all 0. After release, the full 6-edge latency is observed again.
- Macro off: repeat the release test without DEBOUNCE_EDGE_EN -> dout identical, rise=fall=0 throughout.
